// File: rtl/in_serializer.sv
// in_serializer: parallel-to-serial converter with valid/ready intake.
//
// Ports
//   CLK      : sole clock, rising edge
//   RST      : asynchronous active-high reset
//   DATA     : parallel word to serialize (WIDTH bits)
//   VALID    : DATA is valid this cycle
//   READY    : word is accepted at the next edge if VALID=1
//   ABORT    : synchronous discard of the word in flight
//   SER_OUT  : serial bit stream (IDLE_BIT when nothing is presented)
//   SER_VLD  : SER_OUT carries a data bit this cycle
//   SER_LAST : SER_OUT carries the final bit of the current word
//
// A word occupies exactly WIDTH cycles on SER_OUT. A new word accepted during
// the SER_LAST cycle follows with no bubble. All serial outputs are registered.
module in_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DATA,
    input  logic             VALID,
    output logic             READY,
    input  logic             ABORT,
    output logic             SER_OUT,
    output logic             SER_VLD,
    output logic             SER_LAST
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;   // bits still to be presented, next one at the head
    logic [CW-1:0]    cnt;     // bits remaining after the one on SER_OUT
    logic             accept;

    // SER_LAST is only ever set in SHIFT, so it doubles as the
    // "word finishes this cycle" condition for zero-bubble reload.
    assign READY  = (state == IDLE || SER_LAST) && !ABORT;
    assign accept = VALID && READY;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            SER_OUT  <= IDLE_BIT;
            SER_VLD  <= 1'b0;
            SER_LAST <= 1'b0;
        end else if (ABORT) begin
            state    <= IDLE;
            cnt      <= '0;
            SER_OUT  <= IDLE_BIT;
            SER_VLD  <= 1'b0;
            SER_LAST <= 1'b0;
        end else if (accept) begin
            // First bit goes straight to SER_OUT; the register keeps the rest
            // pre-shifted so the head is always the next bit to present.
            state    <= SHIFT;
            cnt      <= CW'(WIDTH - 1);
            SER_VLD  <= 1'b1;
            SER_LAST <= 1'b0;
            if (MSB_FIRST != 0) begin
                SER_OUT <= DATA[WIDTH-1];
                shreg   <= DATA << 1;
            end else begin
                SER_OUT <= DATA[0];
                shreg   <= DATA >> 1;
            end
        end else if (state == SHIFT) begin
            if (SER_LAST) begin
                state    <= IDLE;
                SER_OUT  <= IDLE_BIT;
                SER_VLD  <= 1'b0;
                SER_LAST <= 1'b0;
            end else begin
                cnt      <= cnt - 1'b1;
                SER_LAST <= (cnt == CW'(1));
                if (MSB_FIRST != 0) begin
                    SER_OUT <= shreg[WIDTH-1];
                    shreg   <= shreg << 1;
                end else begin
                    SER_OUT <= shreg[0];
                    shreg   <= shreg >> 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_in_serializer.sv
// Bench for in_serializer: two instances (MSB-first/idle 0 and LSB-first/idle 1)
// share one stimulus stream; a queue-of-bits reference model predicts both.
module tb_in_serializer;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [W-1:0] DATA = '0;
    logic         VALID = 1'b0;
    logic         ABORT = 1'b0;
    logic         ready_m, out_m, vld_m, last_m;
    logic         ready_l, out_l, vld_l, last_l;

    int total = 0;
    int bad   = 0;

    bit q_m[$];   // bits still to appear on the MSB-first stream, head = current
    bit q_l[$];

    in_serializer #(.WIDTH(W), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut_m (
        .CLK(CLK), .RST(RST), .DATA(DATA), .VALID(VALID), .READY(ready_m),
        .ABORT(ABORT), .SER_OUT(out_m), .SER_VLD(vld_m), .SER_LAST(last_m)
    );

    in_serializer #(.WIDTH(W), .MSB_FIRST(0), .IDLE_BIT(1'b1)) dut_l (
        .CLK(CLK), .RST(RST), .DATA(DATA), .VALID(VALID), .READY(ready_l),
        .ABORT(ABORT), .SER_OUT(out_l), .SER_VLD(vld_l), .SER_LAST(last_l)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_outputs();
        chk("vld_m",  vld_m,  q_m.size() > 0);
        chk("out_m",  out_m,  q_m.size() > 0 ? q_m[0] : 1'b0);
        chk("last_m", last_m, q_m.size() == 1);
        chk("vld_l",  vld_l,  q_l.size() > 0);
        chk("out_l",  out_l,  q_l.size() > 0 ? q_l[0] : 1'b1);
        chk("last_l", last_l, q_l.size() == 1);
    endtask

    // One clock of stimulus: called at a falling edge, returns at the next one
    // with the outputs checked against the model.
    task automatic step(input logic v, input logic [W-1:0] d, input logic a);
        bit rdy;
        VALID = v; DATA = d; ABORT = a;
        #1;
        rdy = (q_m.size() <= 1) && !a;
        chk("ready_m", ready_m, rdy);
        chk("ready_l", ready_l, rdy);
        @(posedge CLK);
        if (a) begin
            q_m.delete();
            q_l.delete();
        end else begin
            if (q_m.size() > 0) void'(q_m.pop_front());
            if (q_l.size() > 0) void'(q_l.pop_front());
            if (rdy && v) begin
                for (int i = W - 1; i >= 0; i--) q_m.push_back(d[i]);
                for (int i = 0; i < W; i++)      q_l.push_back(d[i]);
            end
        end
        @(negedge CLK);
        chk_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, W'($urandom), 1'b0);
    endtask

    initial begin
        // reset: outputs idle, READY high during reset
        repeat (2) @(negedge CLK);
        chk_outputs();
        chk("ready_in_rst", ready_m, 1'b1);
        RST = 1'b0;
        #1;
        chk("ready_after_rst", ready_m, 1'b1);
        @(negedge CLK);
        chk_outputs();

        // single word, VALID for one cycle
        step(1'b1, 8'hA5, 1'b0);
        idle(9);

        // back-to-back with VALID held: second word taken on the SER_LAST cycle
        step(1'b1, 8'hF0, 1'b0);
        repeat (8) step(1'b1, 8'h0F, 1'b0);
        idle(9);

        // single low bit word (LSB instance shows 1 then seven 0s)
        step(1'b1, 8'h01, 1'b0);
        idle(9);

        // abort in 3rd bit cycle, then a fresh word
        step(1'b1, 8'hFF, 1'b0);
        idle(2);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h80, 1'b0);
        idle(9);

        // ABORT with VALID in IDLE: nothing accepted
        step(1'b1, 8'h55, 1'b1);
        idle(3);

        // DATA wiggling in flight must not disturb the word
        step(1'b1, 8'h3C, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, W'($urandom), 1'b0);

        // asynchronous reset pulse during the 5th bit
        step(1'b0, 8'h00, 1'b0);
        #2;
        RST = 1'b1;
        #1;
        q_m.delete();
        q_l.delete();
        chk_outputs();
        #1;
        RST = 1'b0;
        #1;
        chk("ready_post_pulse", ready_m, 1'b1);
        @(negedge CLK);
        chk_outputs();
        step(1'b1, 8'h96, 1'b0);
        idle(9);

        // random traffic
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 2) != 0), W'($urandom), ($urandom_range(0, 9) == 0));
        idle(9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/in_serializer.md
IN_SERIALIZER -- requirements
Module: in_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bits per parallel word (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning 1 = shift DATA[WIDTH-1] first, 0 = DATA[0] first.
REQ-003 SHALL have parameter IDLE_BIT, default 0, meaning SER_OUT value whenever no bit is being presented.
REQ-004 SHALL have port CLK  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port DATA  input  WIDTH  parallel word to serialize.
REQ-007 SHALL have port VALID  input  1  DATA is valid this cycle.
REQ-008 SHALL have port READY  output  1  block accepts DATA at the next rising edge if VALID=1.
REQ-009 SHALL have port ABORT  input  1  synchronous discard of the word in flight.
REQ-010 SHALL have port SER_OUT  output  1  serial bit stream, drives the downstream pattern FSM input IN.
REQ-011 SHALL have port SER_VLD  output  1  SER_OUT carries a data bit this cycle.
REQ-012 SHALL have port SER_LAST  output  1  SER_OUT carries the final bit of the current word.

Function
REQ-013 SHALL implement a two-state FSM: IDLE (nothing presented) and SHIFT (presenting bits of a word).
REQ-014 SHALL accept a word on a rising edge where VALID=1, READY=1 and ABORT=0 (handshake); no other condition loads DATA.
REQ-015 SHALL drive READY combinationally = (state==IDLE or SER_LAST=1) and ABORT=0.
REQ-016 On acceptance SHALL load DATA into an internal shift register, present the first bit on SER_OUT with SER_VLD=1 from that edge, set remaining-bit counter to WIDTH-1, enter SHIFT.
REQ-017 In SHIFT, each rising edge without acceptance or ABORT SHALL advance SER_OUT to the next bit and decrement the counter; SER_LAST=1 exactly when counter==0.
REQ-018 A word SHALL occupy exactly WIDTH consecutive cycles with SER_VLD=1; bit order per MSB_FIRST.
REQ-019 Acceptance during the SER_LAST cycle SHALL load the new word with zero bubble: next cycle shows the new word's first bit, SER_VLD stays 1.
REQ-020 SER_LAST cycle without acceptance SHALL return to IDLE: SER_OUT=IDLE_BIT, SER_VLD=0, SER_LAST=0 next cycle.
REQ-021 ABORT=1 at a rising edge SHALL force IDLE, SER_OUT=IDLE_BIT, SER_VLD=0, SER_LAST=0 and discard remaining bits, regardless of state or VALID.
REQ-022 ABORT and VALID both 1 SHALL NOT accept the word (READY=0 that cycle); DATA is not consumed.
REQ-023 DATA changes while in SHIFT without handshake SHALL NOT affect the bits in flight.
REQ-024 SER_OUT, SER_VLD, SER_LAST SHALL be registered outputs (no combinational path from inputs).
REQ-025 In IDLE, SER_OUT SHALL hold IDLE_BIT constantly.

Reset
REQ-026 RST=1 SHALL asynchronously force IDLE, counter=0, shift register=0, SER_OUT=IDLE_BIT, SER_VLD=0, SER_LAST=0.
REQ-027 READY SHALL read 1 during and immediately after reset (ABORT=0), since state is IDLE.
REQ-028 RST asserted mid-word SHALL drop the word; after release the first handshake starts a fresh word at its first bit.

Verification
REQ-029 WIDTH=8, MSB_FIRST=1, single word 8'hA5 with VALID one cycle -> SER_OUT 1,0,1,0,0,1,0,1 over 8 cycles, SER_VLD=1 for all 8, SER_LAST only on 8th, then IDLE_BIT.
REQ-030 Back-to-back 8'hF0 then 8'h0F, VALID held high -> 16 contiguous SER_VLD cycles, bits 11110000 00001111, READY high only in IDLE and the two SER_LAST cycles.
REQ-031 MSB_FIRST=0, word 8'h01 -> SER_OUT 1 in first cycle then 0 for 7 cycles.
REQ-032 ABORT asserted in 3rd bit cycle of 8'hFF -> SER_VLD=0, SER_OUT=IDLE_BIT next cycle; a following handshake on 8'h80 emits 1,0,0,0,0,0,0,0.
REQ-033 ABORT and VALID both 1 in IDLE -> READY=0, no word accepted, SER_VLD stays 0.
REQ-034 RST pulsed asynchronously (between edges) during 5th bit -> SER_VLD=0 and SER_OUT=IDLE_BIT immediately; READY=1 after release.
